sw_status_reporter: RTL
=======================

// Module: sw_status_reporter
// PURPOSE
//  UART-transmit side of the switch-control link: reports the effective switch state (sw_final) to the host.
//  Sends a fixed 6-byte ASCII frame "M<m>U<u>\r\n" on every sw_final change or on a host query byte.
//  Sits between the switch selector (sw_final, rx_done/rx_data) and the UART transmitter (tx_start/tx_data/tx_busy).
// PARAMETERS
//  QUERY_CHAR   8'h3F ("?")  rx byte that requests an immediate status frame
//  REPORT_ON_CHG 1           1: send frame on any sw_final change; 0: query-only
//  ACK_TIMEOUT  15           cycles to wait for tx_busy rise after tx_start before re-issuing the same byte
// PORTS
//  clk       in   1  system clock
//  rst       in   1  reset, asynchronous, active-high
//  sw_final  in   2  effective switches: [1]=mode, [0]=unit
//  rx_done   in   1  1-cycle strobe, rx_data valid
//  rx_data   in   8  received byte
//  tx_busy   in   1  UART TX busy (high from accept to stop-bit end)
//  tx_start  out  1  1-cycle request to send tx_data
//  tx_data   out  8  byte to send; stable from tx_start until tx_busy falls
//  rpt_busy  out  1  high while a frame is in flight (state != IDLE)
// BEHAVIOUR
//  Reset (async): state=IDLE, tx_start=0, tx_data=8'h00, rpt_busy=0, byte_idx=0, pending=0, prev_sw=2'b00,
//   snap=2'b00, ack_cnt=0. Reset mid-frame aborts the frame; no bytes resume.
//  Trigger: trig = (REPORT_ON_CHG && sw_final!=prev_sw) || (rx_done && rx_data==QUERY_CHAR). prev_sw<=sw_final every cycle.
//   Since prev_sw resets to 00, a nonzero sw_final after reset produces one frame.
//  pending set on trig in any state; cleared when a frame is launched from IDLE. Multiple triggers coalesce to one.
//  Snapshot: on launch snap<=sw_final; whole frame uses snap (no mid-frame tearing).
//  Frame bytes by byte_idx: 0:"M"(4D) 1:8'h30+snap[1] 2:"U"(55) 3:8'h30+snap[0] 4:CR(0D) 5:LF(0A).
//  FSM:
//   IDLE    : if pending (or trig this cycle) and !tx_busy -> LOAD, byte_idx=0, snap latched, pending cleared.
//   LOAD    : tx_data<=frame[byte_idx]; -> START.
//   START   : tx_start=1 for exactly 1 cycle, ack_cnt=0 -> WAIT_ACK.
//   WAIT_ACK: tx_busy=1 -> WAIT_DONE; ack_cnt==ACK_TIMEOUT -> START (same byte re-issued); else ack_cnt++.
//   WAIT_DONE: tx_busy=0 -> (byte_idx==5 ? IDLE : byte_idx++, LOAD).
//  Trigger during a frame: frame completes unchanged; pending causes a new frame with fresh snapshot after return to IDLE.
//  Trig and launch in same cycle from IDLE: exactly one frame, pending left 0.
//  tx_start never asserted while tx_busy=1 at launch; tx_data changes only in LOAD.
//  Latency: trig at cycle T (IDLE, tx_busy=0) -> tx_start at T+3 (T+1 pending/launch, LOAD, START).
//  rpt_busy = (state!=IDLE). Non-QUERY rx bytes ("n","m", others) ignored here.
// STRUCTURE
//  Shared package sw_ctrl_pkg: ASCII constants (CH_M, CH_U, CH_0, CH_CR, CH_LF, CH_QUERY, CH_N, CH_MT),
//   FRAME_LEN=6, FSM state encoding typedef. sw_selector uses CH_N/CH_MT from the same package.
//  One natural sub-module: sw_frame_rom (combinational byte_idx,snap -> byte). Counters/FSM stay in top.
// TESTING
//  1 Reset, sw_final=00, query "?" -> bytes 4D 30 55 30 0D 0A, one tx_start per byte, rpt_busy falls after LF.
//  2 sw_final 00->10 (REPORT_ON_CHG=1) -> frame "M1U0\r\n"; tx_start 3 cycles after change.
//  3 During byte 2 of frame, sw_final 10->11->01 -> current frame unchanged, exactly one extra frame "M0U1\r\n".
//  4 Query and sw change in same cycle from IDLE -> exactly one frame with new value.
//  5 TX model holds tx_busy low for 20 cycles after first tx_start -> tx_start re-issued at ACK_TIMEOUT, same byte, no skip.
//  6 Assert rst during byte 3 -> tx_start/tx_data/rpt_busy 0 immediately; after release no resumed bytes unless new trig.

Source files
------------

// File: rtl/sw_ctrl_pkg.sv
// Shared switch-control link constants: ASCII codes, status frame length and
// the status reporter state encoding.
package sw_ctrl_pkg;

    localparam logic [7:0] CH_M     = 8'h4D;
    localparam logic [7:0] CH_U     = 8'h55;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_QUERY = 8'h3F;
    localparam logic [7:0] CH_N     = 8'h6E;
    localparam logic [7:0] CH_MT    = 8'h6D;

    localparam int FRAME_LEN = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } rpt_state_e;

endpackage

// File: rtl/sw_status_reporter_if.sv
// Status reporter link: switch/rx inputs from the selector side and the UART TX
// handshake. master = environment that drives inputs, slave = the reporter.
interface sw_status_reporter_if;
    logic [1:0] sw_final;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       rpt_busy;

    modport master (
        output sw_final, rx_done, rx_data, tx_busy,
        input  tx_start, tx_data, rpt_busy
    );

    modport slave (
        input  sw_final, rx_done, rx_data, tx_busy,
        output tx_start, tx_data, rpt_busy
    );
endinterface

// File: rtl/sw_frame_rom.sv
// Status frame byte lookup: "M<mode>U<unit>\r\n" indexed by byte position.
module sw_frame_rom
    import sw_ctrl_pkg::*;
(
    input  logic [2:0] byte_idx,
    input  logic [1:0] snap,
    output logic [7:0] byte_o
);

    always_comb begin
        byte_o = CH_LF;
        case (byte_idx)
            3'd0:    byte_o = CH_M;
            3'd1:    byte_o = CH_0 | {7'd0, snap[1]};
            3'd2:    byte_o = CH_U;
            3'd3:    byte_o = CH_0 | {7'd0, snap[0]};
            3'd4:    byte_o = CH_CR;
            default: byte_o = CH_LF;
        endcase
    end

endmodule

// File: rtl/sw_status_reporter.sv
// Sends a 6-byte status frame over the UART TX handshake whenever the effective
// switch state changes or the host sends a query byte.
module sw_status_reporter
    import sw_ctrl_pkg::*;
#(
    parameter logic [7:0] QUERY_CHAR    = CH_QUERY,
    parameter bit         REPORT_ON_CHG = 1'b1,
    parameter int         ACK_TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    sw_status_reporter_if.slave   bus
);

    localparam int ACK_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    rpt_state_e       state_q, state_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic             pending_q, pending_d;
    logic [1:0]       prev_sw_q, prev_sw_d;
    logic [1:0]       snap_q, snap_d;
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       rom_byte;
    logic             trig;

    sw_frame_rom u_rom (
        .byte_idx (byte_idx_q),
        .snap     (snap_q),
        .byte_o   (rom_byte)
    );

    assign trig = (REPORT_ON_CHG && (bus.sw_final != prev_sw_q)) ||
                  (bus.rx_done && (bus.rx_data == QUERY_CHAR));

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        pending_d  = pending_q | trig;
        prev_sw_d  = bus.sw_final;
        snap_d     = snap_q;
        ack_cnt_d  = ack_cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                // A trigger seen in the launch cycle is consumed by this frame.
                if ((pending_q || trig) && !bus.tx_busy) begin
                    state_d    = ST_LOAD;
                    byte_idx_d = 3'd0;
                    snap_d     = bus.sw_final;
                    pending_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                tx_data_d = rom_byte;
                state_d   = ST_START;
            end
            ST_START: begin
                tx_start_d = 1'b1;
                ack_cnt_d  = '0;
                state_d    = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.tx_busy)
                    state_d = ST_WAIT_DONE;
                else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT))
                    state_d = ST_START;
                else
                    ack_cnt_d = ack_cnt_q + 1'b1;
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (byte_idx_q == 3'(FRAME_LEN - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= 3'd0;
            pending_q  <= 1'b0;
            prev_sw_q  <= 2'b00;
            snap_q     <= 2'b00;
            ack_cnt_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            pending_q  <= pending_d;
            prev_sw_q  <= prev_sw_d;
            snap_q     <= snap_d;
            ack_cnt_q  <= ack_cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.rpt_busy = (state_q != ST_IDLE);

endmodule
